// File: rtl/morse_key_packer.sv
// morse_key_packer: times presses on a single key line, classifies each press
// as dot (01) or dash (10), and packs up to four symbols MSB-first into an
// 8-bit morse_array. One packed character plus a 1-cycle char_valid strobe is
// emitted after each inter-letter gap. More than four symbols emit 8'hFF with
// sym_overflow.
//
// Optional feature: define SYNC_DEBOUNCE_EN to insert a 2-flop synchroniser
// and a 3-sample majority filter on key_in (key_s lags key_in by 3 cycles).
//
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   key_in       key line, 1 = pressed
//   morse_array  packed character, held until the next character
//   char_valid   1-cycle strobe, morse_array updated this cycle
//   sym_overflow 1-cycle strobe alongside char_valid when >4 symbols seen
module morse_key_packer #(
  parameter int unsigned MIN_TICKS = 1,
  parameter int unsigned DOT_MAX   = 4,
  parameter int unsigned GAP_TICKS = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [7:0] morse_array,
  output logic       char_valid,
  output logic       sym_overflow
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_TICKS);
  localparam logic [CNT_W-1:0] DOT_C = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] GAP_C = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} state_t;

  logic key_s;

`ifdef SYNC_DEBOUNCE_EN
  logic       sync1_q;
  logic       sync2_q;
  logic [1:0] hist_q;

  // Synchroniser plus history of the synchronised key for the majority vote
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 2'b00;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      hist_q  <= {hist_q[0], sync2_q};
    end
  end

  // Majority of the last three synchronised samples; a clean edge shows up 3 cycles late
  assign key_s = (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign key_s = key_in;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       sym_cnt_q, sym_cnt_d;
  logic [7:0]       morse_d;
  logic             valid_d;
  logic             ovf_d;

  logic [CNT_W-1:0] press_inc;
  logic [CNT_W-1:0] gap_inc;
  logic             glitch;
  logic             gap_hit;

  assign press_inc = (press_cnt_q == '1) ? press_cnt_q : press_cnt_q + ONE_C;
  assign gap_inc   = (gap_cnt_q == '1) ? gap_cnt_q : gap_cnt_q + ONE_C;
  assign glitch    = (press_cnt_q < MIN_C);
  assign gap_hit   = (gap_inc >= GAP_C);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (key_s) state_d = PRESS;
      PRESS: begin
        if (!key_s) begin
          if (glitch) state_d = (sym_cnt_q != 3'd0) ? GAP : IDLE;
          else        state_d = GAP;
        end
      end
      GAP: begin
        if (key_s)        state_d = PRESS;
        // A gap that never collected a symbol returns to IDLE silently
        else if (gap_hit) state_d = (sym_cnt_q != 3'd0) ? EMIT : IDLE;
      end
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    press_cnt_d = press_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    shift_d     = shift_q;
    sym_cnt_d   = sym_cnt_q;
    morse_d     = morse_array;
    valid_d     = 1'b0;
    ovf_d       = 1'b0;
    case (state_q)
      IDLE: begin
        gap_cnt_d = '0;
        if (key_s) press_cnt_d = ONE_C;
      end
      PRESS: begin
        if (key_s) begin
          press_cnt_d = press_inc;
        end else begin
          if (!glitch) begin
            shift_d   = {shift_q[5:0], (press_cnt_q <= DOT_C) ? 2'b01 : 2'b10};
            sym_cnt_d = (sym_cnt_q == 3'd7) ? sym_cnt_q : sym_cnt_q + 3'd1;
          end
          press_cnt_d = '0;
          gap_cnt_d   = ONE_C;
        end
      end
      GAP: begin
        if (key_s) begin
          press_cnt_d = ONE_C;
          gap_cnt_d   = '0;
        end else begin
          gap_cnt_d = gap_inc;
        end
      end
      EMIT: begin
        valid_d = 1'b1;
        if (sym_cnt_q > 3'd4) begin
          morse_d = 8'hFF;
          ovf_d   = 1'b1;
        end else begin
          morse_d = shift_q;
        end
        shift_d     = '0;
        sym_cnt_d   = '0;
        gap_cnt_d   = '0;
        press_cnt_d = '0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      press_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      shift_q      <= '0;
      sym_cnt_q    <= '0;
      morse_array  <= '0;
      char_valid   <= 1'b0;
      sym_overflow <= 1'b0;
    end else begin
      press_cnt_q  <= press_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      shift_q      <= shift_d;
      sym_cnt_q    <= sym_cnt_d;
      morse_array  <= morse_d;
      char_valid   <= valid_d;
      sym_overflow <= ovf_d;
    end
  end

endmodule
